// File: rtl/row_packer.sv
// row_packer
//   First stage of the 8x8 DCT transpose. Takes a serial stream of 8-bit
//   pixels and can level-shift each one to signed form. Every 8 consecutive
//   pixels are packed into one 8-lane row. Two row buffers are used in
//   ping-pong fashion, so one row can fill while the previous row waits for
//   the downstream to accept it.
//
// Parameters
//   LEVEL_SHIFT   1: emit pixel-128 as two's complement (MSB inverted)
//                 0: pass the pixel through unchanged
// Ports
//   CLK           clock; all state changes on the rising edge
//   RST           asynchronous, active-high reset
//   STBi          input pixel valid
//   DATi[7:0]     input pixel, unsigned
//   ACKi          ready for a pixel (registered state only)
//   STBo          packed row valid
//   DATo0..DATo7  packed row; DATo0 is the first pixel of the row
//   LASTo         presented row is row 7 of its 8x8 block
//   ACKo          downstream accepts the presented row
module row_packer #(
    parameter bit LEVEL_SHIFT = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STBi,
    input  logic [7:0] DATi,
    output logic       ACKi,
    output logic       STBo,
    output logic [7:0] DATo0,
    output logic [7:0] DATo1,
    output logic [7:0] DATo2,
    output logic [7:0] DATo3,
    output logic [7:0] DATo4,
    output logic [7:0] DATo5,
    output logic [7:0] DATo6,
    output logic [7:0] DATo7,
    output logic       LASTo,
    input  logic       ACKo
);

    logic [7:0] buf0 [8];
    logic [7:0] buf1 [8];
    logic [7:0] rd_row [8];
    logic       full0;
    logic       full1;
    logic       wp;
    logic       rp;
    logic [2:0] pix;
    logic [2:0] row;

    logic       accept;
    logic       wr_done;
    logic       rd_done;
    logic [7:0] pix_in;

    assign pix_in  = LEVEL_SHIFT ? {~DATi[7], DATi[6:0]} : DATi;
    assign accept  = STBi & ACKi;
    assign wr_done = accept & (pix == 3'd7);
    assign rd_done = STBo & ACKo;

    // Writes go in order, so wp always points at an empty buffer while ACKi
    // is high. For the same reason rp never names the buffer being filled
    // while it is readable. A row can complete and a row can drain in the
    // same cycle, and the two flag updates never collide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                buf0[i] <= 8'h00;
                buf1[i] <= 8'h00;
            end
            full0 <= 1'b0;
            full1 <= 1'b0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            pix   <= 3'd0;
            row   <= 3'd0;
        end else begin
            if (accept) begin
                if (wp) buf1[pix] <= pix_in;
                else    buf0[pix] <= pix_in;
                pix <= pix + 3'd1;
            end
            if (wr_done) begin
                wp <= ~wp;
            end
            if (rd_done) begin
                rp  <= ~rp;
                row <= row + 3'd1;
            end
            if (wr_done && !wp)      full0 <= 1'b1;
            else if (rd_done && !rp) full0 <= 1'b0;
            if (wr_done && wp)       full1 <= 1'b1;
            else if (rd_done && rp)  full1 <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rd_row[i] = rp ? buf1[i] : buf0[i];
        end
    end

    assign ACKi  = ~(full0 & full1);
    assign STBo  = rp ? full1 : full0;
    assign LASTo = STBo & (row == 3'd7);

    assign DATo0 = rd_row[0];
    assign DATo1 = rd_row[1];
    assign DATo2 = rd_row[2];
    assign DATo3 = rd_row[3];
    assign DATo4 = rd_row[4];
    assign DATo5 = rd_row[5];
    assign DATo6 = rd_row[6];
    assign DATo7 = rd_row[7];

endmodule

// File: tb/tb_row_packer.sv
module tb_row_packer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       STBi;
    logic [7:0] DATi;
    logic       ACKo;

    logic       ACKi, STBo, LASTo;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       ACKi_n, STBo_n, LASTo_n;
    logic [7:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [7:0] dato [8];

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    row_packer #(.LEVEL_SHIFT(1'b1)) u_shift (
        .CLK(CLK), .RST(RST), .STBi(STBi), .DATi(DATi), .ACKi(ACKi),
        .STBo(STBo), .DATo0(d0), .DATo1(d1), .DATo2(d2), .DATo3(d3),
        .DATo4(d4), .DATo5(d5), .DATo6(d6), .DATo7(d7),
        .LASTo(LASTo), .ACKo(ACKo)
    );

    row_packer #(.LEVEL_SHIFT(1'b0)) u_plain (
        .CLK(CLK), .RST(RST), .STBi(STBi), .DATi(DATi), .ACKi(ACKi_n),
        .STBo(STBo_n), .DATo0(n0), .DATo1(n1), .DATo2(n2), .DATo3(n3),
        .DATo4(n4), .DATo5(n5), .DATo6(n6), .DATo7(n7),
        .LASTo(LASTo_n), .ACKo(ACKo)
    );

    assign dato[0] = d0;
    assign dato[1] = d1;
    assign dato[2] = d2;
    assign dato[3] = d3;
    assign dato[4] = d4;
    assign dato[5] = d5;
    assign dato[6] = d6;
    assign dato[7] = d7;

    typedef struct {
        logic       stbi;
        logic [7:0] dati;
        logic       acko;
        logic       e_acki;
        logic       e_stbo;
        logic [7:0] e_d0;
        logic [7:0] e_d7;
        logic       e_last;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic s, input logic [7:0] d, input logic a);
        STBi = s;
        DATi = d;
        ACKo = a;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        STBi = 1'b0;
        DATi = 8'h00;
        ACKo = 1'b0;
        RST  = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_stbo", {7'd0, STBo}, 8'd0);
        chk("rst_acki", {7'd0, ACKi}, 8'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int sent;
        int rr;
        int prev;
        logic acc;

        STBi = 1'b0;
        DATi = 8'h00;
        ACKo = 1'b1;
        RST  = 1'b1;

        #3;
        chk("reset_stbo",  {7'd0, STBo},  8'd0);
        chk("reset_last",  {7'd0, LASTo}, 8'd0);
        chk("reset_acki",  {7'd0, ACKi},  8'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("reset_dat%0d", i), dato[i], 8'h00);
        chk("reset_plain_dat0", n0, 8'h00);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk("no_spurious_stbo", {7'd0, STBo}, 8'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("no_spurious_stbo2", {7'd0, STBo}, 8'd0);

        // Single row 0..7 with ACKo=1, then back-pressure with ACKo held low.
        for (int k = 0; k < 8; k++)
            vq.push_back('{1'b1, 8'(k), 1'b1, 1'b1, (k == 7), 8'h80, 8'h87, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
        for (int k = 0; k < 16; k++)
            vq.push_back('{1'b1, 8'(8'h10 + k), 1'b0, (k != 15), (k >= 7), 8'h90, 8'h97, 1'b0});
        vq.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h90, 8'h97, 1'b0});
        vq.push_back('{1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h98, 8'h9F, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h98, 8'h9F, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});

        foreach (vq[i]) begin
            step(vq[i].stbi, vq[i].dati, vq[i].acko);
            chk($sformatf("v%0d_acki", i), {7'd0, ACKi}, {7'd0, vq[i].e_acki});
            chk($sformatf("v%0d_stbo", i), {7'd0, STBo}, {7'd0, vq[i].e_stbo});
            if (vq[i].e_stbo) begin
                chk($sformatf("v%0d_dat0", i), d0, vq[i].e_d0);
                chk($sformatf("v%0d_dat7", i), d7, vq[i].e_d7);
                chk($sformatf("v%0d_last", i), {7'd0, LASTo}, {7'd0, vq[i].e_last});
                chk($sformatf("v%0d_plain0", i), n0, vq[i].e_d0 ^ 8'h80);
                chk($sformatf("v%0d_plain7", i), n7, vq[i].e_d7 ^ 8'h80);
            end
        end

        // Full 8x8 block streamed with ACKo=1; pixel value = index.
        do_reset();
        sent = 0;
        rr   = 0;
        prev = 0;
        for (int cyc = 0; cyc < 100 && rr < 8; cyc++) begin
            STBi = (sent < 64);
            DATi = 8'(sent);
            ACKo = 1'b1;
            acc  = STBi & ACKi;
            @(posedge CLK);
            #1;
            if (acc) sent++;
            if (STBo) begin
                for (int c = 0; c < 8; c++)
                    chk($sformatf("blk_r%0d_l%0d", rr, c), dato[c], 8'((8 * rr + c) ^ 8'h80));
                chk($sformatf("blk_r%0d_last", rr), {7'd0, LASTo}, {7'd0, (rr == 7)});
                if (rr > 0) chk($sformatf("blk_r%0d_gap_ok", rr), {7'd0, (cyc - prev <= 8)}, 8'd1);
                prev = cyc;
                rr++;
            end
        end
        chk("blk_rows", 8'(rr), 8'd8);
        chk("blk_pixels", 8'(sent), 8'd64);
        step(1'b0, 8'h00, 1'b1);
        chk("blk_drained", {7'd0, STBo}, 8'd0);

        // Row completes on the same edge the pending row drains.
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
        chk("sim_a_stbo", {7'd0, STBo}, 8'd1);
        chk("sim_a_dat0", d0, 8'h20);
        for (int k = 0; k < 7; k++) step(1'b1, 8'(8'hB0 + k), 1'b0);
        chk("sim_a_hold", d7, 8'h27);
        chk("sim_acki_mid", {7'd0, ACKi}, 8'd1);
        step(1'b1, 8'hB7, 1'b1);
        chk("sim_b_stbo", {7'd0, STBo}, 8'd1);
        chk("sim_b_dat0", d0, 8'h30);
        chk("sim_b_dat7", d7, 8'h37);
        chk("sim_b_acki", {7'd0, ACKi}, 8'd1);
        chk("sim_b_last", {7'd0, LASTo}, 8'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("sim_drained", {7'd0, STBo}, 8'd0);

        // Reset with one row pending and five pixels into the next.
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hC0 + k), 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h60 + k), 1'b0);
        chk("mid_pending_stbo", {7'd0, STBo}, 8'd1);
        STBi = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_stbo", {7'd0, STBo}, 8'd0);
        chk("mid_rst_acki", {7'd0, ACKi}, 8'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h50 + k), 1'b1);
        chk("mid_partial_stbo", {7'd0, STBo}, 8'd0);
        step(1'b1, 8'h57, 1'b1);
        chk("mid_new_stbo", {7'd0, STBo}, 8'd1);
        chk("mid_new_last", {7'd0, LASTo}, 8'd0);
        for (int c = 0; c < 8; c++)
            chk($sformatf("mid_new_l%0d", c), dato[c], 8'(8'hD0 + c));
        step(1'b0, 8'h00, 1'b1);
        chk("mid_drained", {7'd0, STBo}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/row_packer.md
# row_packer

Upstream stage of the 8x8 transpose in the DCT datapath. Accepts a serial stream of 8-bit pixels over an STB/ACK handshake, level-shifts each pixel to signed form, and packs every 8 consecutive pixels into one 8-lane row presented on the transpose's parallel input handshake. Two row buffers (ping-pong) let one row be filled while the previous row waits for the downstream ACK, so the pixel stream is not stalled by single-cycle downstream back-pressure.

## Interface
- LEVEL_SHIFT, 1: 1 = output pixel-128 as two's complement (MSB inverted); 0 = pass pixel unchanged.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high; clock CLK.
- STBi  in  1  input pixel valid.
- DATi  in  8  input pixel, unsigned.
- ACKi  out  1  ready to accept a pixel; transfer occurs on a rising edge with STBi=1 and ACKi=1.
- STBo  out  1  packed row valid.
- DATo0..DATo7  out  8 each  packed row; DATo0 = first pixel accepted for the row, DATo7 = eighth.
- LASTo  out  1  qualifies STBo: 1 when the presented row is row 7 of its 8x8 block.
- ACKo  in  1  downstream accepts row; transfer occurs on a rising edge with STBo=1 and ACKo=1.

## Operation
- State: two 8x8-bit row buffers B0/B1, full flags F0/F1, write pointer wp (1 bit), read pointer rp (1 bit), pixel index pix (3 bits), output row counter row (3 bits).
- Input accept (STBi & ACKi): buffer[wp] lane[pix] <= shifted DATi; pix <= pix+1 (wraps 7->0). When pix==7: F[wp] <= 1, wp <= ~wp.
- ACKi = ~(F0 & F1), combinational from registers only; never depends on STBi or ACKo.
- Output: STBo = F[rp]; DATo lanes = buffer[rp]; LASTo = STBo & (row==7).
- Output transfer (STBo & ACKo): F[rp] <= 0, rp <= ~rp, row <= row+1 (wraps 7->0).
- Simultaneous completion of a write row and drain of the other buffer in one cycle: both updates take effect; both flags updated independently.
- Level shift: out = {~DATi[7], DATi[6:0]} when LEVEL_SHIFT=1; exact mapping 0->0x80 (-128), 128->0x00, 255->0x7F.
- DATo/LASTo are don't-care while STBo=0 but must hold stable for all cycles while STBo=1 and ACKo=0.
- Rows are emitted strictly in input order; no pixel dropped or duplicated under any STBi/ACKo pattern.

## Timing
- Reset (RST=1): F0=F1=0, wp=rp=0, pix=0, row=0, buffers cleared to 0. Outputs: STBo=0, LASTo=0, DATo0..7=0, ACKi=1.
- RST asserted mid-row or with rows pending: partial row and both buffered rows discarded; STBo falls immediately (asynchronous); next accepted pixel is pixel 0 of row 0 of a new block.
- Latency: 8th pixel accepted at edge k -> STBo=1 in the cycle after edge k (1 cycle).
- Throughput: 1 pixel/cycle sustained when ACKo is high whenever STBo is high.
- Back-pressure: with ACKo held 0, exactly 16 pixels are accepted; ACKi drops in the cycle after the 16th pixel's edge. First ACKo transfer at edge m -> ACKi=1 in the cycle after m.
- Empty: both flags 0 -> STBo=0; ACKo ignored.
- Row counter advances only on output transfers, not on input; LASTo therefore tracks emitted rows.

## Test plan
- Reset values: hold RST, check STBo=0, LASTo=0, DATo0..7=0, ACKi=1; release, no spurious STBo.
- Single row, ACKo=1: feed 0,1,...,7 back-to-back -> one STBo pulse 1 cycle after 8th pixel, DATo0..7 = 0x80..0x87, LASTo=0; LEVEL_SHIFT=0 build gives 0x00..0x07.
- Full block streaming: 64 pixels with value = index, ACKo=1 -> 8 rows in order, row r lane c = (8r+c)^0x80, LASTo=1 only on row 7, STBo never gaps more than 8 cycles.
- Back-pressure: ACKo=0, continuous STBi -> 16 pixels accepted, ACKi=0 from 17th cycle, DATo stable; pulse ACKo one cycle -> row 0 retires, ACKi=1 next cycle, row 1 presented unchanged.
- Simultaneous events: time ACKo on same edge as 8th pixel of next row -> no lost/duplicated row, STBo stays 1, data switches to next row.
- Reset mid-operation: assert RST after 5 pixels of row 2 with one row pending -> STBo=0 immediately; next 8 pixels form row 0 with LASTo=0, correct data.
